// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset
// defaults, opcode field bounds and the word-alignment helper.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: reset load, redirect load (word aligned) and sequential
// advance. Redirect takes priority over advance; reset over both.
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        advance,
  output logic [31:0] pc
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // Addition is modulo 2^32, so the top word wraps to zero on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= align_word(target);
    end else if (advance) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: requests a word, holds it until
// downstream accepts it, and handles branch redirects including flushing a
// response that is still in flight.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_valid,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [31:0]         if_pc,
  output logic [OPCODE_W-1:0] if_opcode,
  output logic                misalign_err,
  output logic [15:0]         fetch_count,
  output fetch_state_e        state
);

  // Handshakes: imem_req is a one-cycle pulse; the memory answers with a
  // single imem_valid strobe some cycles later. if_valid stays high until a
  // cycle with stall=0 (or a redirect) retires the held instruction.

  logic [31:0] pc;
  logic        pc_advance;
  logic        accept_rsp;

  assign accept_rsp = (state == ST_WAIT) && imem_valid && !branch_taken;
  assign pc_advance = accept_rsp;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .redirect (branch_taken),
    .target   (branch_target),
    .advance  (pc_advance),
    .pc       (pc)
  );

  assign imem_req  = (state == ST_FETCH) && !rst && !branch_taken;
  assign imem_addr = pc;
  assign if_opcode = if_instr[OPCODE_MSB:OPCODE_LSB];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_FETCH;
      if_valid     <= 1'b0;
      if_instr     <= 32'h0;
      if_pc        <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= 16'h0;
    end else begin
      if (branch_taken && (branch_target[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end
      if (branch_taken) begin
        if_valid <= 1'b0;
        // A request still in flight must be swallowed before refetching;
        // if it lands in this very cycle it is already gone.
        if (((state == ST_WAIT) || (state == ST_FLUSH)) && !imem_valid) begin
          state <= ST_FLUSH;
        end else begin
          state <= ST_FETCH;
        end
      end else begin
        case (state)
          ST_FETCH: state <= ST_WAIT;
          ST_WAIT: begin
            if (imem_valid) begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              if_valid    <= 1'b0;
              fetch_count <= fetch_count + 16'd1;
              state       <= ST_FETCH;
            end
          end
          ST_FLUSH: begin
            if (imem_valid) begin
              state <= ST_FETCH;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed redirect/stall/reset scenarios followed
// by random traffic from a variable-latency memory, all against a reference model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [5:0]  if_opcode;
  logic        misalign_err;
  logic [15:0] fetch_count;
  instr_fetch_unit_pkg::fetch_state_e state;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_opcode     (if_opcode),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count),
    .state         (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: the fetch unit seen as "what is owed to whom".
  // need_req: a request should go out now; owed: a response will be kept;
  // drop_one: one response must be thrown away; held: an instruction waits downstream.
  logic [31:0] m_pc;
  bit          m_need_req, m_owed, m_drop_one, m_held;
  logic [31:0] m_instr, m_ipc;
  bit          m_err;
  logic [15:0] m_cnt;

  bit          seen_req;
  logic [31:0] seen_addr;

  initial begin
    m_pc = 32'h0; m_need_req = 0; m_owed = 0; m_drop_one = 0; m_held = 0;
    m_instr = 32'h0; m_ipc = 32'h0; m_err = 0; m_cnt = 16'h0;
  end

  task automatic model_step(input bit r, input bit bt, input logic [31:0] tgt,
                            input bit v, input logic [31:0] rd, input bit st);
    if (r) begin
      m_pc = 32'h0; m_need_req = 1; m_owed = 0; m_drop_one = 0; m_held = 0;
      m_instr = 32'h0; m_ipc = 32'h0; m_err = 0; m_cnt = 16'h0;
    end else if (bt) begin
      if (tgt % 4 != 0) m_err = 1;
      m_held = 0;
      if ((m_owed || m_drop_one) && !v) begin
        m_owed = 0; m_drop_one = 1; m_need_req = 0;
      end else begin
        m_owed = 0; m_drop_one = 0; m_need_req = 1;
      end
      m_pc = tgt - (tgt % 4);
    end else if (m_need_req) begin
      m_need_req = 0; m_owed = 1;
    end else if (m_owed) begin
      if (v) begin
        m_instr = rd; m_ipc = m_pc; m_held = 1; m_owed = 0;
        m_pc = m_pc + 32'd4;
      end
    end else if (m_held) begin
      if (!st) begin
        m_held = 0; m_cnt = m_cnt + 16'd1; m_need_req = 1;
      end
    end else if (m_drop_one) begin
      if (v) begin
        m_drop_one = 0; m_need_req = 1;
      end
    end
  endtask

  // Driver: apply one cycle of inputs, check request outputs, clock, check state outputs.
  task automatic cycle(input bit r, input bit bt, input logic [31:0] tgt,
                       input bit v, input logic [31:0] rd, input bit st);
    bit exp_req;
    rst = r; branch_taken = bt; branch_target = tgt;
    imem_valid = v; imem_rdata = rd; stall = st;
    #1;
    exp_req = m_need_req && !bt && !r;
    seen_req = imem_req;
    seen_addr = imem_addr;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_step(r, bt, tgt, v, rd, st);
    #1;
    check("if_valid", 32'(if_valid), 32'(m_held));
    check("if_instr", if_instr, m_instr);
    check("if_pc", if_pc, m_ipc);
    check("if_opcode", 32'(if_opcode), 32'(m_instr[31:26]));
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    check("fetch_count", 32'(fetch_count), 32'(m_cnt));
  endtask

  int mem_cd;

  initial begin
    rst = 1; imem_valid = 0; imem_rdata = 0; stall = 0;
    branch_taken = 0; branch_target = 0;

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("rst_count", 32'(fetch_count), 32'h0);

    // Sequential fetch, 1-cycle memory, no stall
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0);
      check("seq_addr", seen_addr, 32'(i * 4));
      cycle(0, 0, 0, 1, $urandom, 0);
      check("seq_if_pc", if_pc, 32'(i * 4));
      cycle(0, 0, 0, 0, 0, 0);
    end
    check("cnt3", 32'(fetch_count), 32'd3);

    // lw opcode and a 5-cycle stall
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h8C22_0004, 1);
    check("lw_opcode", 32'(if_opcode), 32'(6'b100011));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1);
    check("stall_instr", if_instr, 32'h8C22_0004);
    check("stall_cnt", 32'(fetch_count), 32'd3);
    cycle(0, 0, 0, 0, 0, 0);

    // Branch in WAIT, response arrives two cycles later and is discarded
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'h100, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    check("flush_if_valid", 32'(if_valid), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check("flush_addr", seen_addr, 32'h100);

    // Branch and response in the same WAIT cycle
    cycle(0, 1, 32'h40, 1, 32'h1234_5678, 0);
    check("same_cycle_if_valid", 32'(if_valid), 32'd0);
    cycle(0, 0, 0, 0, 0, 0);
    check("same_cycle_addr", seen_addr, 32'h40);
    cycle(0, 0, 0, 1, $urandom, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Misaligned redirect, then wrap from the top word
    cycle(0, 1, 32'h103, 0, 0, 0);
    check("misalign_set", 32'(misalign_err), 32'd1);
    cycle(0, 0, 0, 0, 0, 0);
    check("misalign_addr", seen_addr, 32'h100);
    cycle(0, 0, 0, 1, $urandom, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, $urandom, 0);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("wrap_addr", seen_addr, 32'h0);
    check("misalign_sticky", 32'(misalign_err), 32'd1);

    // Reset while waiting; the late response hits FETCH and is ignored
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hCAFE_F00D, 0);
    check("late_rsp_addr", seen_addr, 32'h0);
    check("late_rsp_req", 32'(seen_req), 32'd1);
    check("late_rsp_if_valid", 32'(if_valid), 32'd0);
    check("rst_clears_err", 32'(misalign_err), 32'd0);
    cycle(0, 0, 0, 1, $urandom, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Random traffic: memory with 1..3 cycle latency plus occasional spurious strobes
    mem_cd = 0;
    for (int n = 0; n < 4000; n++) begin
      bit r, bt, v, st;
      logic [31:0] tgt;
      r  = ($urandom_range(0, 199) == 0);
      bt = ($urandom_range(0, 11) == 0);
      st = ($urandom_range(0, 9) < 4);
      v  = (mem_cd == 1) || ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 7))
        0:       tgt = 32'hFFFF_FFFC;
        1:       tgt = $urandom;
        default: tgt = {$urandom_range(0, 255), 2'b00};
      endcase
      cycle(r, bt, tgt, v, $urandom, st);
      if (mem_cd > 0) mem_cd--;
      if (seen_req) mem_cd = $urandom_range(1, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: PC_STEP, default 4, byte increment per sequential fetch.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  one-cycle fetch request pulse to instruction memory.
REQ-006 Port: imem_addr  output  32  fetch address; valid while imem_req=1.
REQ-007 Port: imem_valid  input  1  response strobe; imem_rdata is valid this cycle.
REQ-008 Port: imem_rdata  input  32  fetched instruction word.
REQ-009 Port: stall  input  1  downstream (control unit/datapath) cannot accept the instruction.
REQ-010 Port: branch_taken  input  1  redirect request this cycle.
REQ-011 Port: branch_target  input  32  redirect address.
REQ-012 Port: if_valid  output  1  if_instr/if_pc/if_opcode hold a live instruction.
REQ-013 Port: if_instr  output  32  registered instruction word.
REQ-014 Port: if_pc  output  32  address of if_instr.
REQ-015 Port: if_opcode  output  6  if_instr[31:26], the opcode field fed to the control unit.
REQ-016 Port: misalign_err  output  1  sticky flag: a branch_target with [1:0]!=0 was received.
REQ-017 Port: fetch_count  output  16  count of instructions delivered (if_valid with stall=0).

Function
REQ-018 States: FETCH, WAIT, HOLD, FLUSH.
REQ-019 FETCH: imem_req=1, imem_addr=pc (combinational from state/pc); next state WAIT.
REQ-020 WAIT: imem_req=0; imem_valid=1 -> if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP, next HOLD; imem_valid=0 -> stay WAIT.
REQ-021 HOLD: if_valid=1 with stall=1 -> outputs frozen, stay HOLD; stall=0 -> instruction consumed this cycle, if_valid<=0, fetch_count<=fetch_count+1, next FETCH.
REQ-022 Latency: imem_req to if_valid = memory latency + 1 cycle; minimum 3 cycles between consecutive imem_req pulses.
REQ-023 Redirect: branch_taken=1 in any state -> pc<={branch_target[31:2],2'b00}, if_valid<=0, imem_req forced 0 that cycle; next FLUSH if in WAIT with imem_valid=0, else FETCH.
REQ-024 branch_taken and imem_valid in same WAIT cycle: branch wins, response discarded, next FETCH.
REQ-025 branch_taken in HOLD: held instruction dropped (not counted), regardless of stall.
REQ-026 FLUSH: imem_req=0; discards exactly one imem_valid response, then FETCH; branch_taken in FLUSH reloads pc, stays FLUSH.
REQ-027 misalign_err set when branch_taken=1 and branch_target[1:0]!=2'b00; cleared only by rst.
REQ-028 PC wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error.
REQ-029 fetch_count wraps 16'hFFFF -> 16'h0000.
REQ-030 imem_valid in FETCH or HOLD (spurious) ignored, no state change.

Reset
REQ-031 rst=1 on rising edge -> state FETCH, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, misalign_err=0, fetch_count=0; imem_req=0 while rst=1.
REQ-032 Reset mid-WAIT: outstanding response abandoned; a late imem_valid after reset ignored (state FETCH).
REQ-033 First imem_req asserted on the first cycle after rst deasserts.

Structure
REQ-034 Shared package holds: fetch state enum, RESET_PC default, opcode field bounds (31:26), PC_STEP.
REQ-035 One sub-module: fetch_pc_reg (pc register with reset load, increment, redirect load, alignment mask).

Verification
REQ-036 Reset, 1-cycle memory latency, stall=0 -> imem_addr 0x0,0x4,0x8; if_pc matches; fetch_count=3 after third consume.
REQ-037 imem_rdata=32'h8C22_0004 (lw) -> if_opcode=6'b100011; stall=1 for 5 cycles -> outputs frozen, no imem_req, fetch_count unchanged.
REQ-038 branch_taken target 0x100 during WAIT, response 2 cycles later -> response discarded, next imem_addr=0x100.
REQ-039 branch_taken and imem_valid same cycle, target 0x40 -> if_valid stays 0, next imem_addr=0x40.
REQ-040 branch_target 0x103 -> pc=0x100, misalign_err=1 until rst; RESET_PC=0xFFFF_FFFC -> second fetch address 0x0.
REQ-041 rst asserted in WAIT, imem_valid arrives during following FETCH -> ignored, if_valid=0, imem_addr=RESET_PC.
